// File: rtl/encoder_4to2_seq.sv
// encoder_4to2_seq: registered priority encoder with a valid/ready output slot.
// Request lines are captured into a pending register; one pending index is
// emitted per handshake and its bit is cleared once served.
// Build option: define ROUND_ROBIN_EN for rotating priority starting at rr_ptr;
// otherwise fixed priority with the highest index winning.
module encoder_4to2_seq #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] D,
    output logic [W-1:0] A,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         ovr
);

    localparam int WP = W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] req;
    logic [N-1:0] serve_mask;
    logic         free;
    logic         grant;
    logic [W-1:0] sel;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;
    logic [W:0]   idx;
    logic         found;
`endif

    // Qualified requests, output slot availability and grant decision
    always_comb begin
        req        = en ? D : '0;
        free       = !out_valid || out_ready;
        grant      = free && (|pending);
        serve_mask = grant ? (N'(1) << sel) : '0;
    end

`ifdef ROUND_ROBIN_EN
    // Rotating priority: first pending bit at or after rr_ptr, ascending with wrap
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr} + WP'(k);
            if (idx >= WP'(N))
                idx = idx - WP'(N);
            if (!found && pending[idx[W-1:0]]) begin
                sel   = idx[W-1:0];
                found = 1'b1;
            end
        end
    end

    // Pointer moves just past the granted index so every bit is reached within N grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (sel == W'(N - 1)) ? '0 : sel + W'(1);
    end
`else
    // Fixed priority: highest pending index wins
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending[W'(i)])
                sel = W'(i);
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: HOLD while an index is presented or another is ready to follow
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = HOLD;
            HOLD:    if (out_ready && !(|pending)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output: the state itself is the valid flag
    always_comb begin
        out_valid = (state == HOLD);
    end

    // Pending capture, index register and sticky overrun flag.
    // A bit served and re-requested on the same edge stays set and is not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A       <= '0;
            pending <= '0;
            ovr     <= 1'b0;
        end else begin
            pending <= (pending & ~serve_mask) | req;
            if (grant)
                A <= sel;
            if (|(req & pending & ~serve_mask))
                ovr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// tb_encoder_4to2_seq: scoreboard bench for encoder_4to2_seq.
// Expected indices are queued when requests are driven and popped on each handshake.
`timescale 1ns/1ps
module tb_encoder_4to2_seq;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] D;
    logic [W-1:0] A;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         ovr;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned sb[$];

    encoder_4to2_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .D         (D),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        D         = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int unsigned k;
        k = 0;
        out_ready = 1'b1;
        D         = '0;
        while ((out_valid || sb.size() != 0) && k < 40) begin
            tick();
            k++;
        end
        check_val({tag, "_sb_empty"}, sb.size(), 0);
        check_val({tag, "_idle"}, out_valid, 0);
    endtask

    // Scoreboard: every accepted index must match the oldest queued expectation
    always @(negedge clk) begin
        int unsigned exp;
        if (rst_n && out_valid && out_ready) begin
            check_val("sb_grant_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check_val("sb_A", A, exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned first;
        int unsigned second;
        int unsigned seq5[4];

        rst_n     = 1'b0;
        en        = 1'b0;
        D         = '0;
        out_ready = 1'b0;
        #2;
        check_val("por_A", A, 0);
        check_val("por_valid", out_valid, 0);
        check_val("por_pending", pending, 0);
        check_val("por_ovr", ovr, 0);
        apply_reset();

        // Asynchronous reset mid-run with pending=1010 and ovr set
        en = 1'b1;
        D  = 4'b1010;
        tick();
        tick();
        D = '0;
        check_val("pre_rst_pending", pending, 4'b1010);
        check_val("pre_rst_valid", out_valid, 1);
        check_val("pre_rst_ovr", ovr, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_A", A, 0);
        check_val("async_rst_valid", out_valid, 0);
        check_val("async_rst_pending", pending, 0);
        check_val("async_rst_ovr", ovr, 0);
        apply_reset();

        // Single request: latency and one-cycle valid
        out_ready = 1'b1;
        en        = 1'b1;
        D         = 4'b0100;
        tick();
        D = '0;
        check_val("single_pending", pending, 4'b0100);
        check_val("single_lat_valid0", out_valid, 0);
        sb.push_back(2);
        tick();
        check_val("single_valid", out_valid, 1);
        check_val("single_A", A, 2);
        tick();
        check_val("single_valid_off", out_valid, 0);
        drain("single");

        // Backpressure: held index is stable until accepted
        apply_reset();
        en = 1'b1;
        D  = 4'b1001;
        tick();
        D = '0;
`ifdef ROUND_ROBIN_EN
        first  = 0;
        second = 3;
`else
        first  = 3;
        second = 0;
`endif
        sb.push_back(first);
        sb.push_back(second);
        tick();
        check_val("bp_valid", out_valid, 1);
        check_val("bp_A", A, first);
        repeat (4) begin
            tick();
            check_val("bp_hold_A", A, first);
            check_val("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        check_val("bp_second_A", A, second);
        check_val("bp_second_valid", out_valid, 1);
        tick();
        check_val("bp_done_valid", out_valid, 0);
        drain("bp");

        // Overrun: D[1] pulsed twice while the slot is blocked
        apply_reset();
        en = 1'b1;
        D  = 4'b0001;
        tick();
        D = '0;
        tick();
        D = 4'b0010;
        tick();
        D = '0;
        tick();
        check_val("ovr_before", ovr, 0);
        D = 4'b0010;
        tick();
        D = '0;
        check_val("ovr_set", ovr, 1);
        check_val("ovr_pending", pending, 4'b0010);
        sb.push_back(0);
        sb.push_back(1);
        drain("ovr");
        check_val("ovr_sticky", ovr, 1);

        // Enable low: requests ignored entirely
        apply_reset();
        en = 1'b0;
        D  = 4'b1111;
        repeat (3) begin
            tick();
            check_val("en0_pending", pending, 0);
            check_val("en0_valid", out_valid, 0);
            check_val("en0_ovr", ovr, 0);
        end
        D = '0;

        // All four requested once: back-to-back grants in priority order
        apply_reset();
        out_ready = 1'b1;
        en        = 1'b1;
`ifdef ROUND_ROBIN_EN
        seq5 = '{0, 1, 2, 3};
`else
        seq5 = '{3, 2, 1, 0};
`endif
        D = 4'b1111;
        tick();
        D = '0;
        for (int i = 0; i < 4; i++) sb.push_back(seq5[i]);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("prio_A", A, seq5[i]);
            check_val("prio_valid", out_valid, 1);
        end
        tick();
        check_val("prio_done_valid", out_valid, 0);
        drain("prio");

`ifdef ROUND_ROBIN_EN
        // Held 1111 for 8 edges: rotation visits every bit
        apply_reset();
        out_ready = 1'b1;
        en        = 1'b1;
        D         = 4'b1111;
        tick();
        for (int i = 0; i < 11; i++) sb.push_back(i % 4);
        for (int i = 0; i < 11; i++) begin
            if (i == 7) D = '0;
            tick();
            check_val("rr_A", A, i % 4);
            check_val("rr_valid", out_valid, 1);
        end
        drain("rr");
`endif

        // Same bit served and re-requested each edge: not an overrun
        apply_reset();
        out_ready = 1'b1;
        en        = 1'b1;
        D         = 4'b0100;
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(2);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) D = '0;
            tick();
            check_val("rereq_A", A, 2);
            check_val("rereq_ovr", ovr, 0);
        end
        drain("rereq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
